// File: rtl/mem_stage_ctrl.sv
`timescale 1ns/1ps
// MEM-stage sequencer: runs the variable-latency data-memory handshake, stalls the
// upstream pipeline while an access is outstanding, and turns taken branches into redirect/flush.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              MEMwmem,
    input  logic              MEMm2reg,
    input  logic [DATA_W-1:0] MEMaluResult,
    input  logic [DATA_W-1:0] MEMdi,
    input  logic [1:0]        MEMjumpType,
    input  logic [DATA_W-1:0] MEMjumpPc,
    input  logic              MEMzero,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] MEMdo,
    output logic              stall,
    output logic              wb_bubble,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              flush,
    output logic              mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             mem_op;
    logic             cnt_last;
    logic             taken;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        mem_op   = MEMwmem | MEMm2reg;
        cnt_last = (cnt == CNT_LAST);
        state_nx = state;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                stall = mem_op;
                if (mem_op) state_nx = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem_ack || cnt_last) state_nx = DONE;
            end
            // DONE is the cycle in which EX/MEM is released; never re-arm here
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        case (MEMjumpType)
            2'b01:   taken = MEMzero;
            2'b10:   taken = ~MEMzero;
            2'b11:   taken = 1'b1;
            default: taken = 1'b0;
        endcase

        wb_bubble   = stall;
        pc_redirect = taken & ~stall;
        flush       = taken & ~stall;
        redirect_pc = MEMjumpPc;
    end

    // dmem_we stays latched for the whole access, so it also marks loads at completion
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            MEMdo      <= '0;
            mem_err    <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        dmem_addr  <= MEMaluResult;
                        dmem_wdata <= MEMdi;
                        dmem_we    <= MEMwmem;
                        dmem_req   <= 1'b1;
                        cnt        <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (dmem_ack) begin
                        if (!dmem_we) MEMdo <= dmem_rdata;
                        dmem_req <= 1'b0;
                    end else if (cnt_last) begin
                        if (!dmem_we) MEMdo <= '0;
                        mem_err  <= 1'b1;
                        dmem_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
`timescale 1ns/1ps
// Bench for mem_stage_ctrl: branch vector table, directed memory sequences,
// randomized transactions against a per-transaction timeline model, and async reset abort.
module tb_mem_stage_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        clrn;
    logic        MEMwmem, MEMm2reg, MEMzero, dmem_ack;
    logic [31:0] MEMaluResult, MEMdi, MEMjumpPc, dmem_rdata;
    logic [1:0]  MEMjumpType;
    logic        dmem_req, dmem_we, stall, wb_bubble, pc_redirect, flush, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, MEMdo, redirect_pc;

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .DATA_W(32)) dut (
        .clk(clk), .clrn(clrn),
        .MEMwmem(MEMwmem), .MEMm2reg(MEMm2reg), .MEMaluResult(MEMaluResult), .MEMdi(MEMdi),
        .MEMjumpType(MEMjumpType), .MEMjumpPc(MEMjumpPc), .MEMzero(MEMzero),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .MEMdo(MEMdo),
        .stall(stall), .wb_bubble(wb_bubble), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc), .flush(flush), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_do;
    logic        exp_err;
    int          last_done;

    typedef struct {
        logic [1:0]  jt;
        logic        z;
        logic [31:0] pc;
        logic        exp_t;
    } br_vec_t;
    br_vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ref_taken(input logic [1:0] jt, input logic z);
        return (jt == 2'd3) || (jt == 2'd1 && z) || (jt == 2'd2 && !z);
    endfunction

    // One cycle with no memory op in MEM; ack noise must be ignored outside BUSY.
    task automatic branch_cycle(input logic [1:0] jt, input logic z, input logic [31:0] pc,
                                input logic exp_t);
        MEMwmem = 1'b0; MEMm2reg = 1'b0;
        MEMjumpType = jt; MEMzero = z; MEMjumpPc = pc;
        dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
        @(negedge clk);
        chk("pc_redirect", pc_redirect, exp_t);
        chk("flush", flush, exp_t);
        chk("redirect_pc", redirect_pc, pc);
        chk("stall_idle", stall, 0);
        chk("req_idle", dmem_req, 0);
        chk("MEMdo_idle", MEMdo, exp_do);
        chk("mem_err_idle", mem_err, exp_err);
        next_cycle();
        MEMjumpType = 2'b00;
        dmem_ack = 1'b0;
    endtask

    // A memory op held in MEM for its whole expected occupancy.
    // k >= 0: ack k cycles after req rises (occupancy k+3); k < 0: never acked (TIMEOUT+2).
    task automatic run_op(input logic wm, input logic mr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rd, input int k);
        int   occ;
        logic load, in_req;
        occ  = (k < 0) ? TIMEOUT + 2 : k + 3;
        load = mr & ~wm;
        MEMwmem = wm; MEMm2reg = mr; MEMaluResult = addr; MEMdi = data;
        MEMjumpType = 2'b00; MEMjumpPc = $urandom; MEMzero = 1'($urandom_range(0, 1));
        for (int c = 0; c < occ; c++) begin
            in_req = (c >= 1) && (c < occ - 1);
            if (k >= 0 && c == k + 1) begin
                dmem_ack = 1'b1; dmem_rdata = rd;
            end else begin
                dmem_ack = in_req ? 1'b0 : 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            @(negedge clk);
            chk("stall", stall, (c < occ - 1));
            chk("wb_bubble", wb_bubble, (c < occ - 1));
            chk("dmem_req", dmem_req, in_req);
            chk("redirect_in_op", {pc_redirect, flush}, 0);
            if (in_req) begin
                chk("dmem_we", dmem_we, wm);
                chk("dmem_addr", dmem_addr, addr);
                chk("dmem_wdata", dmem_wdata, data);
            end
            if (c == occ - 1) begin
                if (load) exp_do = (k < 0) ? 32'h0 : rd;
                if (k < 0) exp_err = 1'b1;
                chk("MEMdo_done", MEMdo, exp_do);
                chk("mem_err_done", mem_err, exp_err);
                last_done = cyc;
            end
            next_cycle();
        end
        MEMwmem = 1'b0; MEMm2reg = 1'b0; dmem_ack = 1'b0;
    endtask

    initial begin
        int          d1, sel, k;
        logic [1:0]  jt;
        logic        z;
        logic [31:0] pc;

        tbl[0] = '{2'b01, 1'b1, 32'h0000_0100, 1'b1};
        tbl[1] = '{2'b01, 1'b0, 32'h0000_0100, 1'b0};
        tbl[2] = '{2'b10, 1'b1, 32'h0000_0104, 1'b0};
        tbl[3] = '{2'b10, 1'b0, 32'h0000_0108, 1'b1};
        tbl[4] = '{2'b11, 1'b0, 32'h0000_010C, 1'b1};
        tbl[5] = '{2'b11, 1'b1, 32'h0000_0110, 1'b1};
        tbl[6] = '{2'b00, 1'b0, 32'h0000_0114, 1'b0};
        tbl[7] = '{2'b00, 1'b1, 32'h0000_0118, 1'b0};

        clrn = 1'b0;
        MEMwmem = 1'b0; MEMm2reg = 1'b0; MEMaluResult = '0; MEMdi = '0;
        MEMjumpType = 2'b00; MEMjumpPc = '0; MEMzero = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        exp_do = '0; exp_err = 1'b0; last_done = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_MEMdo", MEMdo, 0);
        chk("rst_stall", {stall, wb_bubble}, 0);
        chk("rst_redirect", {pc_redirect, flush}, 0);
        chk("rst_mem_err", mem_err, 0);
        clrn = 1'b1;
        next_cycle();

        // Branch resolution table; the quiet cycle after each shows the pulse is one cycle wide
        for (int i = 0; i < 8; i++) begin
            branch_cycle(tbl[i].jt, tbl[i].z, tbl[i].pc, tbl[i].exp_t);
            branch_cycle(2'b00, tbl[i].z, tbl[i].pc, 1'b0);
        end

        run_op(1'b0, 1'b1, 32'h40, 32'h0, 32'hDEADBEEF, 3);
        run_op(1'b1, 1'b0, 32'h44, 32'h12345678, 32'hFFFF0000, 0);
        branch_cycle(2'b00, 1'b0, 32'h0, 1'b0);

        run_op(1'b0, 1'b1, 32'h48, 32'h0, 32'hA5A5A5A5, 0);
        d1 = last_done;
        run_op(1'b0, 1'b1, 32'h4C, 32'h0, 32'h5A5A5A5A, 0);
        chk("done_gap", 32'(last_done - d1), 3);

        run_op(1'b1, 1'b1, 32'h50, 32'hCAFEF00D, 32'h11112222, 1);

        run_op(1'b0, 1'b1, 32'h60, 32'h0, 32'h77777777, -1);
        branch_cycle(2'b11, 1'b0, 32'h200, 1'b1);
        run_op(1'b0, 1'b1, 32'h64, 32'h0, 32'h13572468, 2);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                jt = 2'($urandom_range(0, 3));
                z  = 1'($urandom_range(0, 1));
                pc = $urandom;
                branch_cycle(jt, z, pc, ref_taken(jt, z));
            end else begin
                sel = $urandom_range(1, 3);
                k   = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 5);
                run_op(sel[1], sel[0], $urandom, $urandom, $urandom, k);
            end
        end

        // Asynchronous abort in the middle of an access
        MEMm2reg = 1'b1; MEMaluResult = 32'h80; dmem_ack = 1'b0;
        next_cycle();
        next_cycle();
        chk("req_before_abort", dmem_req, 1);
        #2;
        clrn = 1'b0; MEMm2reg = 1'b0;
        #1;
        chk("abort_req", dmem_req, 0);
        chk("abort_we", dmem_we, 0);
        chk("abort_addr", dmem_addr, 0);
        chk("abort_wdata", dmem_wdata, 0);
        chk("abort_MEMdo", MEMdo, 0);
        chk("abort_mem_err", mem_err, 0);
        chk("abort_stall", {stall, wb_bubble}, 0);
        chk("abort_redirect", {pc_redirect, flush}, 0);
        @(negedge clk);
        clrn = 1'b1;
        exp_do = '0; exp_err = 1'b0;
        next_cycle();
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ack_MEMdo", MEMdo, 0);
            chk("late_ack_req", dmem_req, 0);
            chk("late_ack_stall", stall, 0);
            next_cycle();
        end
        dmem_ack = 1'b0;
        run_op(1'b0, 1'b1, 32'h84, 32'h0, 32'h0BADCAFE, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencer for the MEM stage of the 5-stage pipeline. Drives a variable-latency data-memory handshake for loads and stores, stalls the upstream pipeline registers until the access completes, and resolves branches and jumps latched in EX/MEM into a PC redirect plus a pipeline flush. It sits between the EX/MEM register outputs, the data memory, the PC/IF logic and the MEM/WB register.

## Interface
- TIMEOUT, 16: cycles in BUSY without `dmem_ack` before the access is abandoned (≥2).
- clk  in  1  rising-edge clock
- clrn  in  1  reset, asynchronous, active-low
- MEMwmem  in  1  store in MEM stage
- MEMm2reg  in  1  load in MEM stage
- MEMaluResult  in  32  effective address
- MEMdi  in  32  store data
- MEMjumpType  in  2  00 none, 01 beq (taken if MEMzero), 10 bne (taken if !MEMzero), 11 unconditional
- MEMjumpPc  in  32  branch/jump target
- MEMzero  in  1  ALU zero flag
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  write enable, registered
- dmem_addr  out  32  registered address
- dmem_wdata  out  32  registered write data
- dmem_ack  in  1  access complete; rdata valid this cycle
- dmem_rdata  in  32  load data
- MEMdo  out  32  latched load data to MEM/WB
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- wb_bubble  out  1  MEM/WB loads a bubble
- pc_redirect  out  1  PC loads `redirect_pc`
- redirect_pc  out  32  equals MEMjumpPc
- flush  out  1  synchronously clear IF/ID, ID/EX, EX/MEM
- mem_err  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE; dmem_req, dmem_we, stall, wb_bubble, pc_redirect, flush, mem_err = 0; dmem_addr, dmem_wdata, MEMdo, timeout counter = 0.
- mem_op = MEMwmem | MEMm2reg. If both are set, the access is treated as a store.
- IDLE with mem_op: at the next edge go to BUSY. Load dmem_addr ← MEMaluResult, dmem_wdata ← MEMdi, dmem_we ← MEMwmem, dmem_req ← 1, counter ← 0.
- BUSY: hold all request outputs stable and increment the counter each cycle.
  - On dmem_ack: MEMdo ← dmem_rdata (loads only; stores leave MEMdo unchanged), dmem_req ← 0, go to DONE.
  - Else if counter = TIMEOUT-1: mem_err ← 1, MEMdo ← 0 for loads, dmem_req ← 0, go to DONE.
- DONE: lasts one cycle, then IDLE. The edge leaving DONE is the edge at which EX/MEM advances.
- stall (combinational) = (IDLE & mem_op) | BUSY. It is 0 in DONE.
- wb_bubble = stall.
- taken = (type 01 & MEMzero) | (type 10 & !MEMzero) | type 11.
- pc_redirect = flush = taken & !stall. Branch instructions never assert mem_op, so a redirect always occurs in the first cycle the branch is in MEM.
- mem_err is cleared only by clrn.
- dmem_ack outside BUSY is ignored.

## Timing
- Access cost: the request is first visible 1 cycle after the memory op enters MEM.
- Ack in the first BUSY cycle: stall is high for 2 cycles, then DONE. Total MEM occupancy is 3 cycles.
- Ack k cycles after dmem_req rises: MEM occupancy is k+3 cycles.
- Timeout: occupancy is TIMEOUT+2 cycles.
- Back-to-back memory ops: the DONE→IDLE edge loads the next op, and IDLE immediately re-stalls. There is no dead cycle beyond DONE.
- Redirect/flush: zero latency and asserted for exactly 1 cycle, because the flush clears EX/MEM at that edge.
- clrn low in any state aborts immediately: the FSM returns to IDLE and dmem_req drops asynchronously. A memory-side in-flight ack after reset is ignored.

## Test plan
- Load, addr 0x40, ack 3 cycles after req, rdata 0xDEADBEEF -> dmem_req high 4 cycles, dmem_we=0, stall high 5 cycles, MEMdo=0xDEADBEEF in DONE, mem_err=0.
- Store, addr 0x44, data 0x12345678, ack in the first BUSY cycle -> dmem_we=1, dmem_addr/wdata stable while req, stall high 2 cycles, MEMdo unchanged.
- Two consecutive loads, each acked in the first BUSY cycle -> two DONE pulses 3 cycles apart; each MEMdo is correct.
- Load, no ack, TIMEOUT=16 -> req drops after 16 BUSY cycles, mem_err=1 and stays 1, MEMdo=0; pipeline resumes.
- jumpType 01 with MEMzero=1, MEMjumpPc 0x100 -> pc_redirect=flush=1 for one cycle, redirect_pc=0x100. Same with MEMzero=0 -> no redirect. Repeat for 10 (inverse result) and 11 (always redirect).
- clrn pulsed low during BUSY -> all outputs 0 immediately; a late dmem_ack does not change MEMdo or state.
